// File: rtl/mem_access_unit.sv
// Memory-stage access unit: decodes LDW/STW, checks word alignment, serves SPM accesses
// combinationally and runs bus accesses through a req/grant/ready FSM. Macro: MEM_BUS_TIMEOUT_EN.
module mem_access_unit #(
  parameter logic [2:0] SPM_TAG     = 3'b000,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        ex_en_i,
  input  logic [1:0]  ex_mem_op_i,
  input  logic [31:0] ex_mem_wr_data_i,
  input  logic [31:0] ex_out_i,
  output logic [31:0] out_o,
  output logic        miss_align_o,
  output logic        busy_o,
  output logic        bus_err_o,
  output logic [29:0] spm_addr_o,
  output logic        spm_as_n_o,
  output logic        spm_rw_o,
  output logic [31:0] spm_wr_data_o,
  input  logic [31:0] spm_rd_data_i,
  output logic        bus_req_n_o,
  input  logic        bus_grnt_n_i,
  output logic [29:0] bus_addr_o,
  output logic        bus_as_n_o,
  output logic        bus_rw_o,
  output logic [31:0] bus_wr_data_o,
  input  logic [31:0] bus_rd_data_i,
  input  logic        bus_rdy_n_i
);

  localparam logic [1:0] OpLdw = 2'b01;
  localparam logic [1:0] OpStw = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StAccess, StStall} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_buf_q, rd_buf_d;

  logic is_ld, is_st, valid, aligned, to_spm;

  assign is_ld   = (ex_mem_op_i == OpLdw);
  assign is_st   = (ex_mem_op_i == OpStw);
  assign valid   = ex_en_i & (is_ld | is_st) & ~flush_i;
  assign aligned = (ex_out_i[1:0] == 2'b00);
  assign to_spm  = (ex_out_i[31:29] == SPM_TAG);

  assign miss_align_o  = valid & ~aligned;
  assign spm_addr_o    = ex_out_i[31:2];
  assign spm_rw_o      = is_ld;
  assign spm_wr_data_o = ex_mem_wr_data_i;

  // Holding registers only reach the bus once a transaction is under way.
  assign bus_addr_o    = (state_q != StIdle) ? addr_q  : 30'd0;
  assign bus_rw_o      = (state_q != StIdle) ? rw_q    : 1'b0;
  assign bus_wr_data_o = (state_q != StIdle) ? wdata_q : 32'd0;

`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rd_buf_d    = rd_buf_q;
    out_o       = 32'd0;
    busy_o      = 1'b0;
    bus_err_o   = 1'b0;
    spm_as_n_o  = 1'b1;
    bus_req_n_o = 1'b1;
    bus_as_n_o  = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!valid) begin
          out_o = ex_out_i;
        end else if (!aligned) begin
          out_o = 32'd0;
        end else if (to_spm) begin
          spm_as_n_o = 1'b0;
          out_o      = is_ld ? spm_rd_data_i : 32'd0;
        end else begin
          bus_req_n_o = 1'b0;
          busy_o      = 1'b1;
          out_o       = is_ld ? bus_rd_data_i : 32'd0;
          addr_d      = ex_out_i[31:2];
          rw_d        = is_ld;
          wdata_d     = ex_mem_wr_data_i;
          state_d     = StReq;
        end
      end

      StReq: begin
        bus_req_n_o = 1'b0;
        busy_o      = 1'b1;
        // A flush beats a same-cycle grant: no strobe is ever issued for it.
        if (flush_i) begin
          state_d = StIdle;
        end else if (!bus_grnt_n_i) begin
          bus_as_n_o = 1'b0;
          state_d    = StAccess;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
        end
      end

      StAccess: begin
        if (!bus_rdy_n_i) begin
          out_o    = rw_q ? bus_rd_data_i : 32'd0;
          rd_buf_d = bus_rd_data_i;
          state_d  = stall_i ? StStall : StIdle;
        end else begin
          bus_req_n_o = 1'b0;
          busy_o      = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
          // cnt_q counts completed ACCESS cycles, so this is the TIMEOUT_CYC-th one.
          if (cnt_q == TIMEOUT_CYC - 8'd1) begin
            bus_err_o   = 1'b1;
            bus_req_n_o = 1'b1;
            busy_o      = 1'b0;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end

      StStall: begin
        out_o = rd_buf_q;
        if (!stall_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= 30'd0;
      rw_q     <= 1'b0;
      wdata_q  <= 32'd0;
      rd_buf_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      rd_buf_q <= rd_buf_d;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
